// File: rtl/asqrt_pkg.sv
// asqrt shared constants and FSM state type.
// Used by the FIFO reader, its producer and their benches.
package asqrt_pkg;

  localparam int ASQRT_DWDTH = 9;
  localparam int ASQRT_NBITS = ASQRT_DWDTH - 1;
  localparam int EN_BIT      = ASQRT_DWDTH - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/fifo_rd_isqrt_if.sv
// Bundle of FIFO read port, result handshake and status of fifo_rd_isqrt.
// master: the reader side; slave: FIFO + result consumer side.
interface fifo_rd_isqrt_if
  import asqrt_pkg::*;
#(
  parameter int DWDTH = ASQRT_DWDTH,
  parameter int NBITS = DWDTH - 1
);

  logic             fifo_empty;
  logic [DWDTH-1:0] rdata;
  logic             rinc;
  logic [NBITS/2-1:0] root;
  logic [NBITS/2:0]   rem;
  logic             root_vld;
  logic             root_rdy;
  logic             busy;
  logic [7:0]       drop_cnt;

  modport master (
    input  fifo_empty, rdata, root_rdy,
    output rinc, root, rem, root_vld,
    output busy, drop_cnt
  );

  modport slave (
    output fifo_empty, rdata, root_rdy,
    input  rinc, root, rem, root_vld,
    input  busy, drop_cnt
  );

endinterface

// File: rtl/fifo_rd_isqrt_step.sv
// One restoring square-root iteration (2 operand bits in, 1 root bit out).
// Ports: rem_i/root_i/bits_i partial state in, rem_o/root_o next state out.
module isqrt_step #(
  parameter int NBITS = 8
) (
  input  logic [NBITS/2:0]   rem_i,
  input  logic [NBITS/2-1:0] root_i,
  input  logic [1:0]         bits_i,
  output logic [NBITS/2:0]   rem_o,
  output logic [NBITS/2-1:0] root_o
);

  localparam int RW = NBITS/2 + 1;
  localparam int QW = NBITS/2;
  localparam int TW = NBITS/2 + 2;

  logic [TW-1:0] acc;
  logic [TW-1:0] sub;
  logic [TW:0]   trial;
  logic          ge;

  // Partial rem never exceeds 2*root, so its top bit is
  // clear whenever it gets shifted; truncation is safe.
  assign acc   = TW'({rem_i, bits_i});
  assign sub   = {root_i, 2'b01};
  assign trial = {1'b0, acc} - {1'b0, sub};
  assign ge    = ~trial[TW];

  assign rem_o  = ge ? RW'(trial[TW-1:0]) : RW'(acc);
  assign root_o = QW'({root_i, ge});

endmodule

// File: rtl/fifo_rd_isqrt.sv
// FIFO read-side consumer: drops disabled entries, computes isqrt of others.
// Ports: FWFT FIFO read port, root/rem valid/ready result, busy, drop count.
module fifo_rd_isqrt
  import asqrt_pkg::*;
#(
  parameter int DWDTH = ASQRT_DWDTH,
  parameter int NBITS = DWDTH - 1
) (
  input  logic               rclk_i,
  input  logic               rrstn_i,
  input  logic               fifo_empty_i,
  input  logic [DWDTH-1:0]   rdata_i,
  output logic               rinc_o,
  output logic [NBITS/2-1:0] root_o,
  output logic [NBITS/2:0]   rem_o,
  output logic               root_vld_o,
  input  logic               root_rdy_i,
  output logic               busy_o,
  output logic [7:0]         drop_cnt_o
);

  localparam int QW = NBITS/2;
  localparam int RW = NBITS/2 + 1;
  localparam int CW = (QW > 1) ? $clog2(QW) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(QW - 1);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_CALC = CALC;
  localparam logic [1:0] S_DONE = DONE;

  logic [1:0]       state_q, state_d;
  logic [NBITS-1:0] opnd_q, opnd_d;
  logic [RW-1:0]    rem_q, rem_d;
  logic [QW-1:0]    root_q, root_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [QW-1:0]    res_root_q, res_root_d;
  logic [RW-1:0]    res_rem_q, res_rem_d;
  logic [7:0]       drop_q, drop_d;

  logic [RW-1:0] nrem;
  logic [QW-1:0] nroot;
  logic          pop;
  logic          en;

  isqrt_step #(
    .NBITS (NBITS)
  ) u_step (
    .rem_i  (rem_q),
    .root_i (root_q),
    .bits_i (opnd_q[NBITS-1 -: 2]),
    .rem_o  (nrem),
    .root_o (nroot)
  );

  // Reset gates the pop so no entry is consumed while held.
  assign pop = rrstn_i & ~fifo_empty_i
             & (state_q == S_IDLE);
  assign en  = rdata_i[DWDTH-1];

  always_comb begin
    state_d    = state_q;
    opnd_d     = opnd_q;
    rem_d      = rem_q;
    root_d     = root_q;
    cnt_d      = cnt_q;
    res_root_d = res_root_q;
    res_rem_d  = res_rem_q;
    drop_d     = drop_q;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (pop && en) begin
          opnd_d  = rdata_i[NBITS-1:0];
          rem_d   = '0;
          root_d  = '0;
          cnt_d   = CNT_INIT;
          state_d = S_CALC;
        end else if (pop && drop_q != 8'hFF) begin
          drop_d = drop_q + 8'd1;
        end
      end
      (state_q == S_CALC): begin
        opnd_d = opnd_q << 2;
        rem_d  = nrem;
        root_d = nroot;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          res_root_d = nroot;
          res_rem_d  = nrem;
          state_d    = S_DONE;
        end
      end
      (state_q == S_DONE): begin
        if (root_rdy_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge rclk_i or negedge rrstn_i) begin
    if (!rrstn_i) begin
      state_q    <= S_IDLE;
      opnd_q     <= '0;
      rem_q      <= '0;
      root_q     <= '0;
      cnt_q      <= '0;
      res_root_q <= '0;
      res_rem_q  <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      opnd_q     <= opnd_d;
      rem_q      <= rem_d;
      root_q     <= root_d;
      cnt_q      <= cnt_d;
      res_root_q <= res_root_d;
      res_rem_q  <= res_rem_d;
      drop_q     <= drop_d;
    end
  end

  assign rinc_o     = pop;
  assign root_o     = res_root_q;
  assign rem_o      = res_rem_q;
  assign root_vld_o = (state_q == S_DONE);
  assign busy_o     = (state_q != S_IDLE);
  assign drop_cnt_o = drop_q;

endmodule

// File: tb/tb_fifo_rd_isqrt.sv
// Self-checking bench for fifo_rd_isqrt.
// FIFO and expected results are modelled with queues.
module tb_fifo_rd_isqrt;

  logic clk;
  logic rst_n;

  fifo_rd_isqrt_if #(.DWDTH(9), .NBITS(8)) bus ();

  fifo_rd_isqrt #(.DWDTH(9), .NBITS(8)) dut (
    .rclk_i       (clk),
    .rrstn_i      (rst_n),
    .fifo_empty_i (bus.fifo_empty),
    .rdata_i      (bus.rdata),
    .rinc_o       (bus.rinc),
    .root_o       (bus.root),
    .rem_o        (bus.rem),
    .root_vld_o   (bus.root_vld),
    .root_rdy_i   (bus.root_rdy),
    .busy_o       (bus.busy),
    .drop_cnt_o   (bus.drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [8:0] fq[$];
  int         expq[$];
  int         mdrop = 0;
  int         n_res = 0;
  int         n_cyc = 0;

  logic       s_rinc, s_vld, s_busy;
  int         s_root, s_rem, s_drop;
  logic [8:0] s_entry;

  typedef struct {
    logic [8:0] entry;
    int         root;
    int         rem;
  } vec_t;

  vec_t vt[$];

  function automatic int isqrt(int v);
    int r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic refresh();
    bus.fifo_empty = (fifo_q_size() == 0);
    bus.rdata = (fifo_q_size() != 0) ? fq[0] : 9'h000;
  endtask

  function automatic int fifo_q_size();
    return fq.size();
  endfunction

  task automatic push(logic [8:0] e);
    fq.push_back(e);
    refresh();
  endtask

  // One clock: sample at negedge, run the model, pop after posedge.
  task automatic cyc();
    int op;
    @(negedge clk);
    n_cyc++;
    s_rinc  = bus.rinc;
    s_vld   = bus.root_vld;
    s_busy  = bus.busy;
    s_root  = int'(bus.root);
    s_rem   = int'(bus.rem);
    s_drop  = int'(bus.drop_cnt);
    s_entry = bus.rdata;
    if (!rst_n) begin
      expq.delete();
      mdrop = 0;
      s_rinc = 1'b0;
    end else begin
      if (bus.fifo_empty)
        chk("rinc_while_empty", int'(bus.rinc), 0);
      chk("drop_cnt_model", s_drop, mdrop);
      if (bus.root_vld && bus.root_rdy) begin
        if (expq.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          op = expq.pop_front();
          chk("model_root", s_root, isqrt(op));
          chk("model_rem", s_rem, op - isqrt(op) * isqrt(op));
          n_res++;
        end
      end
      if (bus.rinc && !bus.fifo_empty) begin
        if (bus.rdata[8]) expq.push_back(int'(bus.rdata[7:0]));
        else if (mdrop < 255) mdrop++;
      end
    end
    @(posedge clk);
    #1;
    if (s_rinc && fq.size() != 0) void'(fq.pop_front());
    refresh();
  endtask

  task automatic wait_pop(output int c);
    c = -1;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (s_rinc) begin
        c = n_cyc;
        break;
      end
    end
    if (c < 0) chk("pop_timeout", 0, 1);
  endtask

  task automatic wait_vld(output int c);
    c = -1;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (s_vld) begin
        c = n_cyc;
        break;
      end
    end
    if (c < 0) chk("vld_timeout", 0, 1);
  endtask

  initial begin
    int p, p2, v, h, left, nxt, guard;
    logic [8:0] e;

    rst_n = 1'b0;
    bus.root_rdy = 1'b0;
    refresh();
    #3;
    push(9'h190);
    #1;
    chk("rst_rinc", int'(bus.rinc), 0);
    chk("rst_root", int'(bus.root), 0);
    chk("rst_rem", int'(bus.rem), 0);
    chk("rst_vld", int'(bus.root_vld), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_drop", int'(bus.drop_cnt), 0);
    fq.delete();
    refresh();
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();

    // Discards then an enabled operand
    bus.root_rdy = 1'b1;
    push(9'h0AB);
    push(9'h012);
    push(9'h1C8);
    wait_pop(p);
    cyc();
    chk("discard_b2b_pop", int'(s_rinc), 1);
    wait_pop(p2);
    chk("discard_then_pop_gap", p2 - p, 2);
    chk("drop_cnt_2", s_drop, 2);
    wait_vld(v);
    chk("op200_latency", v - p2, 5);
    chk("op200_root", s_root, 14);
    chk("op200_rem", s_rem, 4);

    // Table of single operands
    vt.push_back('{9'h190, 12, 0});
    vt.push_back('{9'h1FF, 15, 30});
    vt.push_back('{9'h100, 0, 0});
    vt.push_back('{9'h101, 1, 0});
    vt.push_back('{9'h103, 1, 2});
    vt.push_back('{9'h1C8, 14, 4});
    vt.push_back('{9'h1E1, 15, 0});
    vt.push_back('{9'h1E0, 14, 28});
    vt.push_back('{9'h18F, 11, 22});
    for (int i = 0; i < vt.size(); i++) begin
      push(vt[i].entry);
      wait_pop(p);
      chk($sformatf("vec%0d_busy_at_pop", i), int'(s_busy), 0);
      wait_vld(v);
      chk($sformatf("vec%0d_latency", i), v - p, 5);
      chk($sformatf("vec%0d_busy", i), int'(s_busy), 1);
      chk($sformatf("vec%0d_root", i), s_root, vt[i].root);
      chk($sformatf("vec%0d_rem", i), s_rem, vt[i].rem);
    end

    // Back-to-back enabled entries: 6-cycle period
    push(9'h1FF);
    push(9'h100);
    wait_pop(p);
    wait_pop(p2);
    chk("b2b_pop_period", p2 - p, 6);
    wait_vld(v);
    chk("b2b_second_root", s_root, 0);

    // Backpressure
    bus.root_rdy = 1'b0;
    push(9'h131);
    push(9'h164);
    wait_vld(v);
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("bp_vld_held", int'(s_vld), 1);
      chk("bp_root_held", s_root, 7);
      chk("bp_rem_held", s_rem, 0);
      chk("bp_no_pop", int'(s_rinc), 0);
    end
    bus.root_rdy = 1'b1;
    cyc();
    h = n_cyc;
    chk("bp_handshake_vld", int'(s_vld), 1);
    cyc();
    chk("bp_pop_after_hs", int'(s_rinc), 1);
    chk("bp_pop_cycle", n_cyc - h, 1);
    wait_vld(v);
    chk("bp_second_root", s_root, 10);

    // Reset in CALC cycle 2
    push(9'h1C4);
    push(9'h151);
    wait_pop(p);
    cyc();
    rst_n = 1'b0;
    #1;
    chk("arst_rinc", int'(bus.rinc), 0);
    chk("arst_root", int'(bus.root), 0);
    chk("arst_rem", int'(bus.rem), 0);
    chk("arst_vld", int'(bus.root_vld), 0);
    chk("arst_busy", int'(bus.busy), 0);
    chk("arst_drop", int'(bus.drop_cnt), 0);
    cyc();
    cyc();
    rst_n = 1'b1;
    wait_pop(p);
    chk("arst_next_entry", int'(s_entry), 9'h151);
    wait_vld(v);
    chk("arst_root_b", s_root, 9);
    chk("arst_rem_b", s_rem, 0);
    cyc();
    chk("arst_fifo_drained", fq.size(), 0);

    // Drop counter saturation
    for (int i = 0; i < 260; i++)
      push({1'b0, 8'($urandom_range(0, 255))});
    guard = 0;
    while (fq.size() != 0 && guard < 400) begin
      cyc();
      guard++;
    end
    cyc();
    chk("drop_saturate", s_drop, 255);

    // Exhaustive enabled operands with random gaps, discards, backpressure
    h = n_res;
    nxt = 0;
    guard = 0;
    left = 256;
    while ((nxt < 256 || fq.size() != 0 || expq.size() != 0
            || bus.busy) && guard < 20000) begin
      if (nxt < 256 && $urandom_range(0, 3) != 0) begin
        if ($urandom_range(0, 4) == 0)
          push({1'b0, 8'($urandom_range(0, 255))});
        e = {1'b1, 8'(nxt)};
        push(e);
        nxt++;
      end
      bus.root_rdy = ($urandom_range(0, 2) != 0);
      cyc();
      guard++;
    end
    chk("exh_timeout", int'(guard < 20000), 1);
    chk("exh_results", n_res - h, left);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
